// File: rtl/sirv_mrom_icb_ctrl.sv
// ICB slave front-end for a combinational mask ROM.
// Valid/ready semantics on both channels: a beat transfers on the rising
// clock edge where valid and ready are both high; a source that has raised
// valid holds it and its payload unchanged until that transfer happens.
// A single response register decouples the channels.
// - A command is accepted whenever that register is empty, or is being
//   drained in the same cycle.
// - The response appears one cycle after the command is accepted.
// Writes are refused with an error response. The ROM is read-only.
module sirv_mrom_icb_ctrl #(
   parameter int AW = 12,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_icb_cmd_valid,
   output logic          i_icb_cmd_ready,
   input  logic [31:0]   i_icb_cmd_addr,
   input  logic          i_icb_cmd_read,
   input  logic [DW-1:0] i_icb_cmd_wdata,
   input  logic [3:0]    i_icb_cmd_wmask,
   output logic          i_icb_rsp_valid,
   input  logic          i_icb_rsp_ready,
   output logic          i_icb_rsp_err,
   output logic [DW-1:0] i_icb_rsp_rdata,
   output logic [AW-3:0] rom_addr,
   input  logic [DW-1:0] rom_dout,
   output logic          o_dbg_state
);

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

   state_t        r_state;
   logic          r_rsp_err;
   logic [DW-1:0] r_rsp_rdata;

   logic          w_cmd_hs;
   logic          w_rsp_hs;
   logic          w_rsp_valid;
   logic          w_unused;

   // Word address into the ROM; the byte offset and bits above the region
   // are dropped, so misaligned or aliased addresses read the containing word.
   assign rom_addr = i_icb_cmd_addr[AW-1:2];

   assign w_rsp_valid     = (r_state == ST_FULL);
   assign i_icb_cmd_ready = ~w_rsp_valid | i_icb_rsp_ready;
   assign w_cmd_hs        = i_icb_cmd_valid & i_icb_cmd_ready;
   assign w_rsp_hs        = w_rsp_valid & i_icb_rsp_ready;

   assign i_icb_rsp_valid = w_rsp_valid;
   assign i_icb_rsp_err   = r_rsp_err;
   assign i_icb_rsp_rdata = r_rsp_rdata;
   assign o_dbg_state     = r_state;

   // Write payload and address bits outside the word index carry no meaning.
   assign w_unused = ^{i_icb_cmd_wdata, i_icb_cmd_wmask,
                       i_icb_cmd_addr[31:AW], i_icb_cmd_addr[1:0]};

   // Response register FSM: EMPTY/FULL with the response payload held alongside.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_EMPTY;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_cmd_hs) begin
                  r_state <= ST_FULL;
               end
            end
            ST_FULL: begin
               if (w_rsp_hs && !w_cmd_hs) begin
                  r_state <= ST_EMPTY;
               end
            end
            default: r_state <= ST_EMPTY;
         endcase
         // A new command always reloads the payload; a stalled response keeps it.
         if (w_cmd_hs) begin
            if (i_icb_cmd_read) begin
               r_rsp_err   <= 1'b0;
               r_rsp_rdata <= rom_dout;
            end else begin
               r_rsp_err   <= 1'b1;
               r_rsp_rdata <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_sirv_mrom_icb_ctrl.sv
// Directed + random bench for sirv_mrom_icb_ctrl with a reference ROM and
// an expected-response queue.
module tb_sirv_mrom_icb_ctrl;

   localparam int AW = 12;
   localparam int DW = 32;

   logic          clk;
   logic          rst_n;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [31:0]   cmd_addr;
   logic          cmd_read;
   logic [31:0]   cmd_wdata;
   logic [3:0]    cmd_wmask;
   logic          rsp_valid;
   logic          rsp_ready;
   logic          rsp_err;
   logic [31:0]   rsp_rdata;
   logic [AW-3:0] rom_addr;
   logic [31:0]   rom_dout;
   logic          dbg_state;

   int n_checks = 0;
   int n_errs   = 0;

   logic [32:0] exp_q[$];

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   sirv_mrom_icb_ctrl #(.AW(AW), .DW(DW)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_icb_cmd_valid (cmd_valid),
      .i_icb_cmd_ready (cmd_ready),
      .i_icb_cmd_addr  (cmd_addr),
      .i_icb_cmd_read  (cmd_read),
      .i_icb_cmd_wdata (cmd_wdata),
      .i_icb_cmd_wmask (cmd_wmask),
      .i_icb_rsp_valid (rsp_valid),
      .i_icb_rsp_ready (rsp_ready),
      .i_icb_rsp_err   (rsp_err),
      .i_icb_rsp_rdata (rsp_rdata),
      .rom_addr        (rom_addr),
      .rom_dout        (rom_dout),
      .o_dbg_state     (dbg_state)
   );

   // ---------------- reference ROM ----------------
   function automatic logic [31:0] rom_word(input logic [9:0] a);
      case (a)
         10'd0:   rom_word = 32'h7ffff297;
         10'd1:   rom_word = 32'h00028067;
         10'd2:   rom_word = 32'h00000000;
         default: rom_word = {16'hA5C3, 6'h0, a};
      endcase
   endfunction

   assign rom_dout = rom_word(rom_addr);

   // ---------------- check helper ----------------
   task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ---------------- scoreboard ----------------
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
      end else begin
         if (rsp_valid && rsp_ready) begin
            chk("rsp_expected", {32'h0, exp_q.size() != 0}, 33'd1);
            if (exp_q.size() != 0) begin
               chk("rsp_payload", {rsp_err, rsp_rdata}, exp_q.pop_front());
            end
         end
         if (cmd_valid && cmd_ready) begin
            if (cmd_read) exp_q.push_back({1'b0, rom_word(cmd_addr[AW-1:2])});
            else          exp_q.push_back({1'b1, 32'h0});
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_cmd(input logic v, input logic rd, input logic [31:0] a,
                            input logic [31:0] wd);
      cmd_valid = v;
      cmd_read  = rd;
      cmd_addr  = a;
      cmd_wdata = wd;
      cmd_wmask = rd ? 4'h0 : 4'hF;
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int drain;
      rst_n     = 1'b0;
      rsp_ready = 1'b1;
      drive_cmd(1'b0, 1'b1, 32'h0, 32'h0);

      // reset values
      repeat (2) @(negedge clk);
      chk("rst_rsp_valid", {32'h0, rsp_valid}, 33'd0);
      chk("rst_rsp_err",   {32'h0, rsp_err},   33'd0);
      chk("rst_rsp_rdata", {1'b0, rsp_rdata},  33'd0);
      rst_n = 1'b1;
      #1;
      chk("post_rst_cmd_ready", {32'h0, cmd_ready}, 33'd1);

      // read 0x1000 -> word 0, latency 1
      tick();
      drive_cmd(1'b1, 1'b1, 32'h0000_1000, 32'h0);
      @(negedge clk);
      chk("t1_rom_addr",  {23'h0, rom_addr},    33'd0);
      chk("t1_cmd_ready", {32'h0, cmd_ready},   33'd1);
      tick();
      drive_cmd(1'b0, 1'b1, 32'h0, 32'h0);
      @(negedge clk);
      chk("t1_rsp_valid", {32'h0, rsp_valid},   33'd1);
      chk("t1_rsp",       {rsp_err, rsp_rdata}, {1'b0, 32'h7ffff297});
      tick();
      @(negedge clk);
      chk("t1_rsp_idle",  {32'h0, rsp_valid},   33'd0);

      // back-to-back reads 0x0, 0x4
      tick();
      drive_cmd(1'b1, 1'b1, 32'h0, 32'h0);
      @(negedge clk);
      chk("t2_cmd_ready0", {32'h0, cmd_ready}, 33'd1);
      tick();
      drive_cmd(1'b1, 1'b1, 32'h4, 32'h0);
      @(negedge clk);
      chk("t2_cmd_ready1", {32'h0, cmd_ready},   33'd1);
      chk("t2_rsp0_valid", {32'h0, rsp_valid},   33'd1);
      chk("t2_rsp0",       {rsp_err, rsp_rdata}, {1'b0, 32'h7ffff297});
      tick();
      drive_cmd(1'b0, 1'b1, 32'h0, 32'h0);
      @(negedge clk);
      chk("t2_rsp1_valid", {32'h0, rsp_valid},   33'd1);
      chk("t2_rsp1",       {rsp_err, rsp_rdata}, {1'b0, 32'h00028067});
      tick();
      @(negedge clk);
      chk("t2_rsp_idle",   {32'h0, rsp_valid},   33'd0);

      // write 0x8 refused, then read 0x8 returns ROM content
      tick();
      drive_cmd(1'b1, 1'b0, 32'h8, 32'hdeadbeef);
      tick();
      drive_cmd(1'b1, 1'b1, 32'h8, 32'h0);
      @(negedge clk);
      chk("t3_wr_rsp", {rsp_valid, rsp_err, rsp_rdata[30:0]}, {1'b1, 1'b1, 31'h0});
      chk("t3_wr_rdata", {1'b0, rsp_rdata}, 33'd0);
      tick();
      drive_cmd(1'b0, 1'b1, 32'h0, 32'h0);
      @(negedge clk);
      chk("t3_rd_valid", {32'h0, rsp_valid},   33'd1);
      chk("t3_rd_rsp",   {rsp_err, rsp_rdata}, {1'b0, 32'h00000000});

      // stalled response with a waiting command, then no-bubble reload
      tick();
      rsp_ready = 1'b0;
      drive_cmd(1'b1, 1'b1, 32'h4, 32'h0);
      tick();
      drive_cmd(1'b1, 1'b1, 32'h0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t4_stall_valid", {32'h0, rsp_valid},   33'd1);
         chk("t4_stall_rsp",   {rsp_err, rsp_rdata}, {1'b0, 32'h00028067});
         chk("t4_stall_ready", {32'h0, cmd_ready},   33'd0);
         tick();
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("t4_release_ready", {32'h0, cmd_ready}, 33'd1);
      tick();
      drive_cmd(1'b0, 1'b1, 32'h0, 32'h0);
      @(negedge clk);
      chk("t4_next_valid", {32'h0, rsp_valid},   33'd1);
      chk("t4_next_rsp",   {rsp_err, rsp_rdata}, {1'b0, 32'h7ffff297});
      tick();
      @(negedge clk);
      chk("t4_idle", {32'h0, rsp_valid}, 33'd0);

      // upper address bits ignored
      tick();
      drive_cmd(1'b1, 1'b1, 32'hFFFF_F004, 32'h0);
      @(negedge clk);
      chk("t5_rom_addr", {23'h0, rom_addr}, 33'd1);
      tick();
      drive_cmd(1'b0, 1'b1, 32'h0, 32'h0);
      @(negedge clk);
      chk("t5_rsp", {rsp_err, rsp_rdata}, {1'b0, 32'h00028067});

      // reset while a response is pending
      tick();
      rsp_ready = 1'b0;
      drive_cmd(1'b1, 1'b1, 32'h0, 32'h0);
      tick();
      drive_cmd(1'b0, 1'b1, 32'h0, 32'h0);
      @(negedge clk);
      chk("t6_pending", {32'h0, rsp_valid}, 33'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", {32'h0, rsp_valid},   33'd0);
      chk("t6_rst_rsp",   {rsp_err, rsp_rdata}, 33'd0);
      chk("t6_rst_ready", {32'h0, cmd_ready},   33'd1);
      @(negedge clk);
      rsp_ready = 1'b1;
      #2 rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("t6_no_rsp",    {32'h0, rsp_valid}, 33'd0);
      chk("t6_ready",     {32'h0, cmd_ready}, 33'd1);

      // random traffic with backpressure
      for (int i = 0; i < 80; i++) begin
         tick();
         if (!(cmd_valid && !cmd_ready)) begin
            drive_cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                      {$urandom_range(0, 65535), 4'h0, 6'($urandom_range(0, 15)),
                       2'($urandom_range(0, 3))},
                      $urandom);
         end
         rsp_ready = 1'($urandom_range(0, 2) != 0);
      end
      // wait for the command in flight (if any) to be accepted before dropping valid
      drain = 0;
      while (cmd_valid && !cmd_ready && drain < 20) begin
         rsp_ready = 1'b1;
         tick();
         drain++;
      end
      tick();
      drive_cmd(1'b0, 1'b1, 32'h0, 32'h0);
      rsp_ready = 1'b1;
      drain = 0;
      while (exp_q.size() != 0 && drain < 20) begin
         @(negedge clk);
         drain++;
      end
      #1;
      chk("drain_empty", {1'b0, 32'(exp_q.size())}, 33'd0);

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule

// File: doc/sirv_mrom_icb_ctrl.md
SIRV_MROM_ICB_CTRL -- requirements
Module: sirv_mrom_icb_ctrl

Interface
REQ-001 SHALL have parameter AW, default 12, meaning byte-address width of the ROM region (4KB).
REQ-002 SHALL have parameter DW, default 32, meaning data width; only 32 is supported.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state is clocked on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning reset: asynchronous assert, active-low.
REQ-005 SHALL have port i_icb_cmd_valid, input, 1, meaning command request.
REQ-006 SHALL have port i_icb_cmd_ready, output, 1, meaning command accepted.
REQ-007 SHALL have port i_icb_cmd_addr, input, 32, meaning byte address.
REQ-008 SHALL have port i_icb_cmd_read, input, 1, meaning 1 = read, 0 = write.
REQ-009 SHALL have port i_icb_cmd_wdata, input, 32, meaning write data (ignored).
REQ-010 SHALL have port i_icb_cmd_wmask, input, 4, meaning byte mask (ignored).
REQ-011 SHALL have port i_icb_rsp_valid, output, 1, meaning response available.
REQ-012 SHALL have port i_icb_rsp_ready, input, 1, meaning response consumed.
REQ-013 SHALL have port i_icb_rsp_err, output, 1, meaning bus error for this response.
REQ-014 SHALL have port i_icb_rsp_rdata, output, 32, meaning read data.
REQ-015 SHALL have port rom_addr, output, AW-2, meaning word address to the mask ROM.
REQ-016 SHALL have port rom_dout, input, 32, meaning combinational ROM word for rom_addr.

Function
REQ-017 SHALL drive rom_addr = i_icb_cmd_addr[AW-1:2] combinationally; bits [31:AW] and [1:0] ignored.
REQ-018 SHALL assert i_icb_cmd_ready = ~rsp_valid | i_icb_rsp_ready (one-entry response register, full throughput).
REQ-019 SHALL define cmd handshake as i_icb_cmd_valid & i_icb_cmd_ready; rsp handshake as i_icb_rsp_valid & i_icb_rsp_ready.
REQ-020 SHALL, on a read cmd handshake, capture rom_dout into rsp_rdata and clear rsp_err in the same edge.
REQ-021 SHALL, on a write cmd handshake, set rsp_err=1 and rsp_rdata=32'h0; the ROM is never modified.
REQ-022 SHALL assert i_icb_rsp_valid exactly one cycle after the cmd handshake (latency 1).
REQ-023 SHALL hold rsp_valid, rsp_err, rsp_rdata stable while rsp_valid=1 and i_icb_rsp_ready=0.
REQ-024 SHALL, on simultaneous rsp handshake and cmd handshake, load the new response (rsp_valid stays 1, no bubble).
REQ-025 SHALL, on rsp handshake without cmd handshake, clear rsp_valid next cycle.
REQ-026 SHALL keep i_icb_cmd_ready=1 when idle, regardless of i_icb_cmd_valid.
REQ-027 SHALL implement state as two states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1); EMPTY->FULL on cmd handshake; FULL->EMPTY on rsp handshake without cmd handshake; FULL->FULL otherwise.
REQ-028 SHALL never drop or duplicate a response: responses equal accepted commands, in order.
REQ-029 SHALL ignore misaligned addr[1:0]; no error for misalignment.

Reset
REQ-030 SHALL, while rst_n=0, force rsp_valid=0, rsp_err=0, rsp_rdata=32'h0 asynchronously.
REQ-031 SHALL, after rst_n deasserts, have i_icb_cmd_ready=1 in the first cycle.
REQ-032 SHALL discard any pending response on reset mid-transfer; no response is issued for it afterwards.

Verification
REQ-033 SHALL pass: ROM model word0=0x7ffff297; read addr 0x00001000, rsp_ready=1 -> rsp_valid next cycle, rdata=0x7ffff297, err=0.
REQ-034 SHALL pass: back-to-back reads addr 0x0 then 0x4, rsp_ready=1 -> responses on consecutive cycles, rdata 0x7ffff297 then 0x00028067, cmd_ready held 1.
REQ-035 SHALL pass: write addr 0x8 wdata 0xdeadbeef -> rsp err=1, rdata=0; subsequent read of 0x8 returns ROM value 0x00000000.
REQ-036 SHALL pass: read 0x4 with rsp_ready=0 for 3 cycles -> rsp_valid held, rdata 0x00028067 stable, cmd_ready=0; releases 1 cycle after rsp_ready=1.
REQ-037 SHALL pass: read addr 0xFFFFF004 -> rom_addr=1, rdata=0x00028067 (upper bits ignored).
REQ-038 SHALL pass: rst_n pulsed low while rsp_valid=1 -> rsp_valid=0 immediately, no response after release, cmd_ready=1.
